// File: rtl/dds_multiwave_gen.sv
`default_nettype none
// ============================================================================
//  Module      : dds_multiwave_gen
//  Description : Phase-accumulator DDS driving an 8-bit parallel DAC with
//                sine/saw/square/triangle, double-buffered gain/offset/duty.
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_multiwave_gen #(
    parameter int PHASE_W = 32,
    parameter int DAC_W   = 8,
    parameter int LUT_AW  = 8,
    parameter int AMP_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               cfg_load,
    input  logic [2:0]         cfg_wave,
    input  logic [PHASE_W-1:0] cfg_freq,
    input  logic [DAC_W-1:0]   cfg_duty,
    input  logic [AMP_W-1:0]   cfg_amp,
    input  logic [DAC_W-1:0]   cfg_offset,
    output logic [LUT_AW-1:0]  rom_addr,
    input  logic [DAC_W-1:0]   rom_q,
    output logic [DAC_W-1:0]   dac_da,
    output logic               dac_clka,
    output logic               dac_wra,
    output logic               dac_mode,
    output logic               dac_sleep,
    output logic               wrap,
    output logic               cfg_pend
);

    localparam logic [2:0]       c_WAVE_SAW = 3'd1;
    localparam logic [2:0]       c_WAVE_SQR = 3'd2;
    localparam logic [2:0]       c_WAVE_TRI = 3'd3;
    localparam logic [DAC_W-1:0] c_DAC_MAX  = '1;

    // Phase accumulator and configuration banks
    logic [PHASE_W-1:0] r_phase;
    logic               r_wrap;
    logic               r_cfg_pend;
    logic [2:0]         r_act_wave,   r_pnd_wave;
    logic [PHASE_W-1:0] r_act_freq,   r_pnd_freq;
    logic [DAC_W-1:0]   r_act_duty,   r_pnd_duty;
    logic [AMP_W-1:0]   r_act_amp,    r_pnd_amp;
    logic [DAC_W-1:0]   r_act_offset, r_pnd_offset;

    // Sample pipeline
    logic               r_s1_vld;
    logic [2:0]         r_s1_wave;
    logic [DAC_W-1:0]   r_s1_calc;
    logic [AMP_W-1:0]   r_s1_amp;
    logic [DAC_W-1:0]   r_s1_off;
    logic               r_s2_vld;
    logic [DAC_W-1:0]   r_s2_scaled;
    logic [DAC_W-1:0]   r_s2_off;
    logic [DAC_W-1:0]   r_dac;
    logic               r_dac_sleep;

    logic [PHASE_W:0]           w_sum;
    logic                       w_carry;
    logic                       w_apply;
    logic [DAC_W-1:0]           w_tap;
    logic [DAC_W-1:0]           w_calc;
    logic                       w_s1_sine;
    logic [DAC_W-1:0]           w_raw;
    logic [AMP_W:0]             w_gain;
    logic [DAC_W+AMP_W:0]       w_prod;
    logic [DAC_W-1:0]           w_scaled;
    logic [DAC_W:0]             w_off_sum;
    logic [DAC_W-1:0]           w_sat;

    assign w_sum   = {1'b0, r_phase} + {1'b0, r_act_freq};
    assign w_carry = en & w_sum[PHASE_W];
    // A zero increment never wraps, so pending settings would otherwise wait forever
    assign w_apply = r_cfg_pend & (w_carry | ~en | (r_act_freq == '0));

    assign w_tap    = r_phase[PHASE_W-1 -: DAC_W];
    assign rom_addr = r_phase[PHASE_W-1 -: LUT_AW];

    always_comb begin
        w_calc = '0;
        case (r_act_wave)
            c_WAVE_SAW: w_calc = w_tap;
            c_WAVE_SQR: w_calc = (w_tap < r_act_duty) ? c_DAC_MAX : '0;
            c_WAVE_TRI: w_calc = w_tap[DAC_W-1] ? ~{w_tap[DAC_W-2:0], 1'b0}
                                                :  {w_tap[DAC_W-2:0], 1'b0};
            default:    w_calc = '0;
        endcase
    end

    assign w_s1_sine = (r_s1_wave == 3'd0) | r_s1_wave[2];
    assign w_raw     = w_s1_sine ? rom_q : r_s1_calc;
    assign w_gain    = {1'b0, r_s1_amp} + {{AMP_W{1'b0}}, 1'b1};
    assign w_prod    = {{(AMP_W+1){1'b0}}, w_raw} * {{DAC_W{1'b0}}, w_gain};
    assign w_scaled  = DAC_W'(w_prod >> AMP_W);

    assign w_off_sum = {1'b0, r_s2_scaled} + {1'b0, r_s2_off};
    assign w_sat     = w_off_sum[DAC_W] ? c_DAC_MAX : w_off_sum[DAC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_wrap  <= 1'b0;
        end else if (en) begin
            r_phase <= w_sum[PHASE_W-1:0];
            r_wrap  <= w_sum[PHASE_W];
        end else begin
            r_phase <= '0;
            r_wrap  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_pend   <= 1'b0;
            r_pnd_wave   <= '0;
            r_pnd_freq   <= '0;
            r_pnd_duty   <= '0;
            r_pnd_amp    <= '0;
            r_pnd_offset <= '0;
            r_act_wave   <= '0;
            r_act_freq   <= '0;
            r_act_duty   <= '0;
            r_act_amp    <= '0;
            r_act_offset <= '0;
        end else begin
            // A load coinciding with an apply stays pending for the next event
            if (cfg_load) begin
                r_cfg_pend   <= 1'b1;
                r_pnd_wave   <= cfg_wave;
                r_pnd_freq   <= cfg_freq;
                r_pnd_duty   <= cfg_duty;
                r_pnd_amp    <= cfg_amp;
                r_pnd_offset <= cfg_offset;
            end else if (w_apply) begin
                r_cfg_pend   <= 1'b0;
            end
            if (w_apply) begin
                r_act_wave   <= r_pnd_wave;
                r_act_freq   <= r_pnd_freq;
                r_act_duty   <= r_pnd_duty;
                r_act_amp    <= r_pnd_amp;
                r_act_offset <= r_pnd_offset;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld    <= 1'b0;
            r_s1_wave   <= '0;
            r_s1_calc   <= '0;
            r_s1_amp    <= '0;
            r_s1_off    <= '0;
            r_s2_vld    <= 1'b0;
            r_s2_scaled <= '0;
            r_s2_off    <= '0;
            r_dac       <= '0;
            r_dac_sleep <= 1'b1;
        end else begin
            r_s1_vld    <= en;
            r_s1_wave   <= r_act_wave;
            r_s1_calc   <= w_calc;
            r_s1_amp    <= r_act_amp;
            r_s1_off    <= r_act_offset;
            r_s2_vld    <= en & r_s1_vld;
            r_s2_scaled <= w_scaled;
            r_s2_off    <= r_s1_off;
            r_dac       <= (en & r_s2_vld) ? w_sat : '0;
            r_dac_sleep <= ~en;
        end
    end

    assign dac_da    = r_dac;
    assign dac_sleep = r_dac_sleep;
    assign wrap      = r_wrap;
    assign cfg_pend  = r_cfg_pend;
    assign dac_clka  = ~clk;
    assign dac_wra   = ~clk;
    assign dac_mode  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_dds_multiwave_gen.sv
`default_nettype none
// Testbench for dds_multiwave_gen: sample-level reference model compared
// every cycle, plus directed literal checks for each scenario.
module tb_dds_multiwave_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        cfg_load = 1'b0;
    logic [2:0]  cfg_wave = '0;
    logic [31:0] cfg_freq = '0;
    logic [7:0]  cfg_duty = '0;
    logic [7:0]  cfg_amp = '0;
    logic [7:0]  cfg_offset = '0;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_q = '0;
    logic [7:0]  dac_da;
    logic        dac_clka, dac_wra, dac_mode, dac_sleep, wrap, cfg_pend;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;
    logic [7:0] rom [256];

    dds_multiwave_gen #(.PHASE_W(32), .DAC_W(8), .LUT_AW(8), .AMP_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load),
        .cfg_wave(cfg_wave), .cfg_freq(cfg_freq), .cfg_duty(cfg_duty),
        .cfg_amp(cfg_amp), .cfg_offset(cfg_offset), .rom_addr(rom_addr),
        .rom_q(rom_q), .dac_da(dac_da), .dac_clka(dac_clka), .dac_wra(dac_wra),
        .dac_mode(dac_mode), .dac_sleep(dac_sleep), .wrap(wrap), .cfg_pend(cfg_pend)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++)
            rom[i] = 8'(int'(128.0 + 127.0 * $sin(6.283185307179586 * i / 256.0)));
    end

    always @(posedge clk) rom_q <= rom[rom_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Output sample for a given phase under a given configuration
    function automatic int sample(input longint ph, input int wave, input int duty,
                                  input int amp, input int off);
        int t;
        int raw;
        int s;
        t = int'(ph >> 24);
        case (wave)
            1:       raw = t;
            2:       raw = (t < duty) ? 255 : 0;
            3:       raw = (t < 128) ? 2 * t : 255 - 2 * (t - 128);
            default: raw = int'(rom[t]);
        endcase
        s = (raw * (amp + 1)) / 256;
        return (s + off > 255) ? 255 : s + off;
    endfunction

    // Reference model state
    longint m_phase, a_freq, p_freq, m_sum;
    int     a_wave, a_duty, a_amp, a_off, p_wave, p_duty, p_amp, p_off;
    bit     m_pend, m_wrap, m_sleep, m_carry, m_apply;
    int     m_dac, pv0, pv1;
    bit     pe0, pe1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; a_freq <= 0; p_freq <= 0;
            a_wave <= 0; a_duty <= 0; a_amp <= 0; a_off <= 0;
            p_wave <= 0; p_duty <= 0; p_amp <= 0; p_off <= 0;
            m_pend <= 0; m_wrap <= 0; m_sleep <= 1; m_dac <= 0;
            pv0 <= 0; pv1 <= 0; pe0 <= 0; pe1 <= 0;
        end else begin
            m_sum   = m_phase + a_freq;
            m_carry = en && (m_sum >= 64'h1_0000_0000);
            m_apply = m_pend && (m_carry || !en || a_freq == 0);
            if (en) begin
                m_dac <= pe1 ? pv1 : 0;
                pv1   <= pv0;
                pe1   <= pe0;
                pv0   <= sample(m_phase, a_wave, a_duty, a_amp, a_off);
                pe0   <= 1'b1;
            end else begin
                m_dac <= 0;
                pe0   <= 1'b0;
                pe1   <= 1'b0;
            end
            m_phase <= en ? (m_sum & 64'hFFFF_FFFF) : 0;
            m_wrap  <= m_carry;
            m_sleep <= !en;
            if (m_apply) begin
                a_wave <= p_wave; a_freq <= p_freq; a_duty <= p_duty;
                a_amp  <= p_amp;  a_off  <= p_off;
            end
            if (cfg_load) begin
                p_wave <= int'(cfg_wave); p_freq <= longint'(cfg_freq);
                p_duty <= int'(cfg_duty); p_amp  <= int'(cfg_amp);
                p_off  <= int'(cfg_offset); m_pend <= 1'b1;
            end else if (m_apply) begin
                m_pend <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("dac_da", dac_da, m_dac);
            chk("wrap", wrap, m_wrap);
            chk("cfg_pend", cfg_pend, m_pend);
            chk("dac_sleep", dac_sleep, m_sleep);
            chk("rom_addr", rom_addr, m_phase >> 24);
            chk("dac_clka", dac_clka, 1);
            chk("dac_wra", dac_wra, 1);
            chk("dac_mode", dac_mode, 1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int w, input longint f, input int d, input int a, input int o);
        cfg_wave = 3'(w); cfg_freq = 32'(f); cfg_duty = 8'(d);
        cfg_amp = 8'(a); cfg_offset = 8'(o); cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic wait_wrap(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (wrap) break;
        end
        chk("wait for wrap", wrap, 1);
    endtask

    task automatic wait_pend_clear(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!cfg_pend) break;
        end
        chk("wait for cfg apply", cfg_pend, 0);
    endtask

    int vmin, vmax;

    initial begin
        tick(2);
        chk_on = 1'b1;
        chk("reset dac_da", dac_da, 0);
        chk("reset dac_sleep", dac_sleep, 1);
        chk("reset wrap", wrap, 0);
        chk("reset cfg_pend", cfg_pend, 0);
        chk("reset rom_addr", rom_addr, 0);
        rst_n = 1'b1;

        // Saw ramp, parked load applies immediately
        load(1, 64'd1 << 24, 0, 255, 0);
        chk("t1 pend after load", cfg_pend, 1);
        tick(2);
        chk("t1 applied while parked", cfg_pend, 0);
        en = 1'b1;
        tick(13);
        chk("t1 ramp value", dac_da, 10);
        chk("t1 rom_addr", rom_addr, 13);
        tick(243);
        chk("t1 wrap pulse", wrap, 1);
        chk("t1 dac at wrap", dac_da, 253);
        tick(1);
        chk("t1 wrap one cycle", wrap, 0);
        tick(2);
        chk("t1 ramp restart", dac_da, 0);
        tick(1);
        chk("t1 ramp step", dac_da, 1);

        // Square duty 64, then duty 0
        load(2, 64'd1 << 24, 64, 255, 0);
        wait_wrap(300);
        tick(3);
        chk("t2 square high first", dac_da, 255);
        tick(63);
        chk("t2 square high last", dac_da, 255);
        tick(1);
        chk("t2 square low", dac_da, 0);
        tick(100);
        load(2, 64'd1 << 24, 0, 255, 0);
        wait_wrap(300);
        tick(4);
        chk("t2 duty zero", dac_da, 0);
        tick(200);

        // Triangle with gain and saturating offset
        load(3, 64'd1 << 24, 0, 127, 200);
        wait_wrap(300);
        tick(3);
        chk("t3 triangle base", dac_da, 200);
        vmin = 255; vmax = 0;
        for (int i = 0; i < 256; i++) begin
            if (int'(dac_da) < vmin) vmin = int'(dac_da);
            if (int'(dac_da) > vmax) vmax = int'(dac_da);
            tick(1);
        end
        chk("t3 peak saturates", vmax, 255);
        chk("t3 minimum", vmin, 200);

        // Sine from ROM at half speed
        load(0, 64'd1 << 23, 0, 255, 0);
        wait_wrap(300);
        chk("t4 addr first", rom_addr, 0);
        tick(1);
        chk("t4 addr held", rom_addr, 0);
        tick(1);
        chk("t4 addr next", rom_addr, 1);
        tick(1);
        chk("t4 sine sample", dac_da, 128);
        tick(600);

        // Mid-period reload, last load wins at the wrap
        load(1, 64'd1 << 24, 0, 255, 0);
        wait_pend_clear(1100);
        tick(100);
        load(2, 64'd1 << 24, 128, 255, 0);
        chk("t5 pend set", cfg_pend, 1);
        tick(20);
        load(3, 64'd1 << 24, 0, 255, 0);
        wait_wrap(300);
        chk("t5 applied at wrap", cfg_pend, 0);
        tick(2);
        chk("t5 last saw sample", dac_da, 255);
        tick(2);
        chk("t5 first triangle step", dac_da, 2);
        tick(50);

        // Zero frequency, park, async reset
        load(1, 0, 0, 255, 0);
        wait_pend_clear(300);
        tick(3);
        load(1, 64'd1 << 24, 0, 255, 0);
        chk("t6 pend with freq 0", cfg_pend, 1);
        tick(1);
        chk("t6 applied next clk", cfg_pend, 0);
        tick(50);
        en = 1'b0;
        tick(1);
        chk("t6 sleep on park", dac_sleep, 1);
        chk("t6 dac zero on park", dac_da, 0);
        tick(5);
        en = 1'b1;
        tick(40);
        load(2, 64'd1 << 24, 100, 200, 10);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 async dac_da", dac_da, 0);
        chk("t6 async dac_sleep", dac_sleep, 1);
        chk("t6 async wrap", wrap, 0);
        chk("t6 async cfg_pend", cfg_pend, 0);
        chk("t6 async rom_addr", rom_addr, 0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        chk("t6 cfg discarded", rom_addr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
